// File: rtl/cpu_defs_pkg.sv
// Shared datapath opcode/op constants, instruction field positions
// and issuer state encodings.
package cpu_defs_pkg;

    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] HALT_OPC = 3'b111;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_SH  = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 13;
    localparam int OP_HI  = 12;
    localparam int OP_LO  = 11;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE   = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_ADVANCE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    function automatic logic is_halt(input logic [15:0] i);
        return i[OPC_HI:OPC_LO] == HALT_OPC;
    endfunction

    function automatic logic [15:0] mk_instr(
        input logic [2:0]  opc,
        input logic [1:0]  op,
        input logic [10:0] rest
    );
        return {opc, op, rest};
    endfunction

endpackage

// File: rtl/instr_issuer_prog_mem.sv
// Program RAM for the instruction issuer: one synchronous write port,
// one asynchronous read port.
module instr_issuer_prog_mem #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [15:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [15:0]       rdata
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_issuer.sv
// Start/wait handshake initiator: walks a PC through program RAM, issuing
// each word to the control FSM. Optional macro ISSUE_STEP_EN gates ADVANCE on step.
module instr_issuer
    import cpu_defs_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int WAIT_MAX = 63
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [15:0]       prog_data,
    input  logic              start,
    input  logic              step,
    input  logic              w,
    output logic              s,
    output logic [15:0]       instr,
    output logic [2:0]        opcode,
    output logic [1:0]        op,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        icount
);

    localparam logic [7:0]        WMAX    = 8'(WAIT_MAX);
    localparam logic [ADDR_W-1:0] PC_LAST = ADDR_W'(DEPTH - 1);

    logic [2:0]        state;
    logic [7:0]        wcnt;
    logic              idle_like;
    logic              mem_we;
    logic              timeout;
    logic              adv_go;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] raddr;
    logic [15:0]       rdata;
    logic [15:0]       fetch;

    assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
    assign mem_we    = prog_we && idle_like;
    assign timeout   = wcnt >= WMAX;
    assign pc_nxt    = pc + 1'b1;
    assign raddr     = (state == ST_ADVANCE) ? pc_nxt : '0;

    // A write in the same cycle as start must be visible to the first fetch.
    assign fetch = (mem_we && prog_addr == raddr) ? prog_data : rdata;

`ifdef ISSUE_STEP_EN
    assign adv_go = step;
`else
    logic unused_step;
    assign unused_step = step;
    assign adv_go      = 1'b1;
`endif

    assign opcode = instr[OPC_HI:OPC_LO];
    assign op     = instr[OP_HI:OP_LO];

    instr_issuer_prog_mem #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_prog_mem (
        .clk  (clk),
        .we   (mem_we),
        .waddr(prog_addr),
        .wdata(prog_data),
        .raddr(raddr),
        .rdata(rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= ST_IDLE;
            s      <= 1'b0;
            instr  <= '0;
            pc     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            icount <= '0;
            wcnt   <= '0;
        end else begin
            wcnt <= '0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state  <= ST_ISSUE;
                        pc     <= '0;
                        instr  <= fetch;
                        s      <= !is_halt(fetch);
                        icount <= '0;
                        err    <= 1'b0;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (is_halt(instr)) begin
                        state <= ST_DONE;
                        s     <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (!w) begin
                        state <= ST_WAIT;
                        s     <= 1'b0;
                    end else if (timeout) begin
                        state <= ST_DONE;
                        s     <= 1'b0;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 8'd1;
                    end
                end
                ST_WAIT: begin
                    if (w) begin
                        state <= ST_ADVANCE;
                        if (icount != 8'hFF) begin
                            icount <= icount + 8'd1;
                        end
                    end else if (timeout) begin
                        state <= ST_DONE;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 8'd1;
                    end
                end
                ST_ADVANCE: begin
                    if (adv_go) begin
                        if (pc == PC_LAST) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_ISSUE;
                            pc    <= pc_nxt;
                            instr <= fetch;
                            s     <= !is_halt(fetch);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    s     <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_issuer.sv
// Directed self-checking bench for instr_issuer with a simple
// control-FSM responder model on the s/w handshake.
module tb_instr_issuer;
    import cpu_defs_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [15:0] prog_data = '0;
    logic        start = 1'b0;
    logic        step = 1'b1;
    logic        w;
    logic        s;
    logic [15:0] instr;
    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [3:0]  pc;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  icount;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int lat = 3;
    int cnt = 0;
    bit hang = 1'b0;
    logic s_q = 1'b0;

    instr_issuer dut (
        .clk      (clk),
        .reset    (reset),
        .prog_we  (prog_we),
        .prog_addr(prog_addr),
        .prog_data(prog_data),
        .start    (start),
        .step     (step),
        .w        (w),
        .s        (s),
        .instr    (instr),
        .opcode   (opcode),
        .op       (op),
        .pc       (pc),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .icount   (icount)
    );

    always #5 clk = ~clk;

    // Control FSM model: accept on s, retire lat cycles later.
    always @(posedge clk) begin
        if (!reset || hang) begin
            w   <= 1'b1;
            cnt <= 0;
        end else if (w && s) begin
            w   <= 1'b0;
            cnt <= lat;
        end else if (!w) begin
            if (cnt <= 1) w <= 1'b1;
            else cnt <= cnt - 1;
        end
    end

    always @(posedge clk) begin
        s_q <= s;
        if (s && !s_q) pulses <= pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        int p0;
        bit ok;

        repeat (3) @(negedge clk);
        chk("rst_s", {31'd0, s}, 32'd0);
        chk("rst_instr", {16'd0, instr}, 32'd0);
        chk("rst_pc", {28'd0, pc}, 32'd0);
        chk("rst_flags", {28'd0, busy, done, err, 1'b0}, 32'd0);
        chk("rst_icount", {24'd0, icount}, 32'd0);
        reset = 1'b1;

        // 1: MOV_IMM, ADD, HALT
        wr(4'd0, 16'hD007);
        wr(4'd1, 16'hA012);
        wr(4'd2, 16'hE000);
        p0 = pulses;
        pulse_start();
        wait_done("t1_done", 200);
        chk("t1_pulses", pulses - p0, 32'd2);
        chk("t1_icount", {24'd0, icount}, 32'd2);
        chk("t1_pc", {28'd0, pc}, 32'd2);
        chk("t1_opcode", {29'd0, opcode}, 32'd7);
        chk("t1_busy", {31'd0, busy}, 32'd0);

        // 2: full program, no wrap
        for (int i = 0; i < 16; i++) begin
            wr(4'(i), mk_instr(OPC_ALU, 2'(i), 11'(i)));
        end
        p0 = pulses;
        pulse_start();
        wait_done("t2_done", 1000);
        chk("t2_pc", {28'd0, pc}, 32'd15);
        chk("t2_icount", {24'd0, icount}, 32'd16);
        chk("t2_instr", {16'd0, instr}, 32'hA00F | 32'h1800);
        chk("t2_op", {30'd0, op}, 32'd3);
        chk("t2_pulses", pulses - p0, 32'd16);

        // 3: responder never drops w -> timeout
        hang = 1'b1;
        pulse_start();
        repeat (63) @(negedge clk);
        chk("t3_pre_err", {31'd0, err}, 32'd0);
        chk("t3_pre_s", {31'd0, s}, 32'd1);
        @(negedge clk);
        chk("t3_err", {31'd0, err}, 32'd1);
        chk("t3_s", {31'd0, s}, 32'd0);
        chk("t3_done", {31'd0, done}, 32'd1);
        hang = 1'b0;

        // 4: reset during WAIT
        wr(4'd0, mk_instr(OPC_ALU, OP_CMP, 11'd5));
        wr(4'd1, mk_instr(OPC_ALU, OP_AND, 11'd6));
        wr(4'd2, 16'hE000);
        pulse_start();
        chk("t4_err_clr", {31'd0, err}, 32'd0);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (busy && !s && !w) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("t4_reach_wait", {31'd0, ok}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("t4_s", {31'd0, s}, 32'd0);
        chk("t4_pc", {28'd0, pc}, 32'd0);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        pulse_start();
        wait_done("t4_done", 200);
        chk("t4_icount", {24'd0, icount}, 32'd2);
        chk("t4_pc_end", {28'd0, pc}, 32'd2);

        // 5: writes while busy ignored, in DONE honoured
        wr(4'd0, mk_instr(OPC_ALU, OP_ADD, 11'd1));
        wr(4'd1, mk_instr(OPC_ALU, OP_MVN, 11'd2));
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        prog_we   = 1'b1;
        prog_addr = 4'd1;
        prog_data = 16'hE000;
        @(negedge clk);
        prog_we = 1'b0;
        wait_done("t5_done_a", 200);
        chk("t5_busy_we_icount", {24'd0, icount}, 32'd2);
        wr(4'd1, 16'hE000);
        pulse_start();
        wait_done("t5_done_b", 200);
        chk("t5_icount", {24'd0, icount}, 32'd1);
        chk("t5_pc", {28'd0, pc}, 32'd1);
        chk("t5_instr", {16'd0, instr}, 32'hE000);

        // start and write same cycle: new word fetched
        p0 = pulses;
        @(negedge clk);
        start     = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 4'd0;
        prog_data = 16'hE123;
        @(negedge clk);
        start   = 1'b0;
        prog_we = 1'b0;
        wait_done("t5_sw_done", 20);
        chk("t5_sw_instr", {16'd0, instr}, 32'hE123);
        chk("t5_sw_icount", {24'd0, icount}, 32'd0);
        chk("t5_sw_pulses", pulses - p0, 32'd0);

`ifdef ISSUE_STEP_EN
        // 6: single-step hold in ADVANCE
        wr(4'd0, mk_instr(OPC_ALU, OP_ADD, 11'd3));
        wr(4'd1, mk_instr(OPC_ALU, OP_AND, 11'd4));
        wr(4'd2, 16'hE000);
        step = 1'b0;
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (busy && !s && w) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("t6_reach_adv", {31'd0, ok}, 32'd1);
        repeat (20) @(negedge clk);
        chk("t6_hold_pc", {28'd0, pc}, 32'd0);
        chk("t6_hold_err", {31'd0, err}, 32'd0);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        chk("t6_step_pc", {28'd0, pc}, 32'd1);
        chk("t6_step_s", {31'd0, s}, 32'd1);
        step = 1'b1;
        wait_done("t6_done", 200);
        chk("t6_icount", {24'd0, icount}, 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
